// File: rtl/upcnt_bcd_ssd_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upcnt_bcd_ssd_scan_pkg
// Description : Shared seven-segment glyphs, digit-enable patterns and BCD type
// Revision    : 1.0 - initial release
// ============================================================================
package upcnt_bcd_ssd_scan_pkg;

    typedef logic [3:0] bcd_t;

    // Active-low {a,b,c,d,e,f,g,dp}; dp is always off
    localparam logic [7:0] SEG_GLYPH_0 = 8'b0000_0011;
    localparam logic [7:0] SEG_GLYPH_1 = 8'b1001_1111;
    localparam logic [7:0] SEG_GLYPH_2 = 8'b0010_0101;
    localparam logic [7:0] SEG_GLYPH_3 = 8'b0000_1101;
    localparam logic [7:0] SEG_GLYPH_4 = 8'b1001_1001;
    localparam logic [7:0] SEG_GLYPH_5 = 8'b0100_1001;
    localparam logic [7:0] SEG_GLYPH_6 = 8'b0100_0001;
    localparam logic [7:0] SEG_GLYPH_7 = 8'b0001_1111;
    localparam logic [7:0] SEG_GLYPH_8 = 8'b0000_0001;
    localparam logic [7:0] SEG_GLYPH_9 = 8'b0000_1001;
    localparam logic [7:0] SEG_BLANK   = 8'hFF;

    localparam logic [3:0] SSD_DIGIT_EN [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage : upcnt_bcd_ssd_scan_pkg
`default_nettype wire

// File: rtl/upcnt_bcd_ssd_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : upcnt_bcd_ssd_scan_if
// Description : Enable input and display/count outputs of the scanned counter
// Revision    : 1.0 - initial release
// ============================================================================
interface upcnt_bcd_ssd_scan_if;
    import upcnt_bcd_ssd_scan_pkg::*;

    logic       count_en;
    logic [7:0] segs;
    logic [3:0] ssd_ctl;
    bcd_t       bcd_tens;
    bcd_t       bcd_ones;
    logic       carry;

    modport master (
        input  count_en,
        output segs,
        output ssd_ctl,
        output bcd_tens,
        output bcd_ones,
        output carry
    );

    modport slave (
        output count_en,
        input  segs,
        input  ssd_ctl,
        input  bcd_tens,
        input  bcd_ones,
        input  carry
    );

endinterface : upcnt_bcd_ssd_scan_if
`default_nettype wire

// File: rtl/upcnt_bcd_ssd_scan_bcd2ssd.sv
`default_nettype none
// ============================================================================
// Module      : bcd2ssd
// Description : Combinational BCD digit to active-low seven-segment glyph
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2ssd
    import upcnt_bcd_ssd_scan_pkg::*;
(
    input  bcd_t       i_bcd,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_GLYPH_0;
            4'd1:    o_seg = SEG_GLYPH_1;
            4'd2:    o_seg = SEG_GLYPH_2;
            4'd3:    o_seg = SEG_GLYPH_3;
            4'd4:    o_seg = SEG_GLYPH_4;
            4'd5:    o_seg = SEG_GLYPH_5;
            4'd6:    o_seg = SEG_GLYPH_6;
            4'd7:    o_seg = SEG_GLYPH_7;
            4'd8:    o_seg = SEG_GLYPH_8;
            4'd9:    o_seg = SEG_GLYPH_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule : bcd2ssd
`default_nettype wire

// File: rtl/upcnt_bcd_ssd_scan.sv
`default_nettype none
// ============================================================================
// Module      : upcnt_bcd_ssd_scan
// Description : Two-digit BCD up-counter with 4-digit scanned SSD output
// Revision    : 1.0 - initial release
// ============================================================================
module upcnt_bcd_ssd_scan
    import upcnt_bcd_ssd_scan_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000,
    parameter int MAX_TENS = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    upcnt_bcd_ssd_scan_if.master  bus
);

    localparam int            c_presc_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int            c_scan_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_tick_last = c_presc_w'(TICK_DIV - 1);
    localparam logic [c_scan_w-1:0]  c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam bcd_t          c_max_tens  = bcd_t'(MAX_TENS);

    logic [c_presc_w-1:0] r_presc;
    logic [c_scan_w-1:0]  r_scan;
    logic [1:0]           r_idx;
    bcd_t                 r_tens;
    bcd_t                 r_ones;
    logic                 r_carry;
    logic [7:0]           r_segs;
    logic [3:0]           r_ssd_ctl;

    logic                 w_tick;
    logic                 w_scan_wrap;
    bcd_t                 w_digit;
    logic [7:0]           w_glyph;

    assign w_tick      = bus.count_en && (r_presc == c_tick_last);
    assign w_scan_wrap = (r_scan == c_scan_last);
    assign w_digit     = r_idx[0] ? r_tens : r_ones;

    bcd2ssd u_bcd2ssd (
        .i_bcd (w_digit),
        .o_seg (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc   <= '0;
            r_scan    <= '0;
            r_idx     <= '0;
            r_tens    <= '0;
            r_ones    <= '0;
            r_carry   <= 1'b0;
            r_segs    <= SEG_GLYPH_0;
            r_ssd_ctl <= SSD_DIGIT_EN[0];
        end else begin
            // Prescaler freezes (keeps its phase) while disabled
            if (bus.count_en) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end

            r_carry <= 1'b0;
            if (w_tick) begin
                if (r_ones != 4'd9) begin
                    r_ones <= r_ones + 4'd1;
                end else begin
                    r_ones <= '0;
                    if (r_tens < c_max_tens) begin
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_tens  <= '0;
                        r_carry <= 1'b1;
                    end
                end
            end

            r_scan <= w_scan_wrap ? '0 : r_scan + 1'b1;
            if (w_scan_wrap) begin
                r_idx <= r_idx + 2'd1;
            end

            // Display registers follow the pre-edge index and digit values
            r_ssd_ctl <= SSD_DIGIT_EN[r_idx];
            r_segs    <= r_idx[1] ? SEG_BLANK : w_glyph;
        end
    end

    assign bus.segs     = r_segs;
    assign bus.ssd_ctl  = r_ssd_ctl;
    assign bus.bcd_tens = r_tens;
    assign bus.bcd_ones = r_ones;
    assign bus.carry    = r_carry;

endmodule : upcnt_bcd_ssd_scan
`default_nettype wire
